ap_mult_err_sweep: RTL

AP_MULT_ERR_SWEEP -- requirements
Module: ap_mult_err_sweep

---
 rtl/ap_mult_err_sweep.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/ap_mult_err_sweep.sv
// ---------------------------------------------------------------------------
// ap_mult_err_sweep
// Drives every operand pair {op_a,op_b} = 0 .. 2^(2W)-1 into an external
// approximate multiplier with LAT internal register stages. Each returned
// product is compared against the exact product, and the block collects
// error statistics: how many pairs were wrong, the sum of absolute errors,
// the largest error, and the first operand pair that reached it.
//
// Ports
//   clk      : clock, rising edge active
//   rst_n    : asynchronous active-low reset
//   start    : begin a sweep (sampled only when idle or done)
//   abort    : stop a running sweep (honoured only while busy)
//   op_a     : registered operand A to the multiplier (upper index bits)
//   op_b     : registered operand B to the multiplier (lower index bits)
//   prod_ap  : approximate product returned by the multiplier
//   busy     : sweep in progress (issuing or draining)
//   done     : sweep finished, results valid (level)
//   err_cnt  : number of pairs with a nonzero error
//   err_sum  : sum of absolute errors
//   err_max  : largest absolute error
//   worst_a  : op_a of the first pair reaching err_max
//   worst_b  : op_b of the first pair reaching err_max
// ---------------------------------------------------------------------------
module ap_mult_err_sweep #(
    parameter int LAT = 1,
    parameter int W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    input  logic [2*W-1:0]   prod_ap,
    output logic             busy,
    output logic             done,
    output logic [2*W:0]     err_cnt,
    output logic [31:0]      err_sum,
    output logic [2*W-1:0]   err_max,
    output logic [W-1:0]     worst_a,
    output logic [W-1:0]     worst_b
);

    localparam int PW = 2 * W;

    localparam logic [PW-1:0] LAST_IDX = {PW{1'b1}};
    // Index issued just before the last one; issuing past it ends RUN.
    localparam logic [PW-1:0] PEN_IDX  = {{(PW-1){1'b1}}, 1'b0};
    localparam logic [PW-1:0] IDX_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_ONE  = {{PW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_nxt;

    // Stage 0 of the delay line is the operand register itself; stage LAT
    // lines up with the product the multiplier returns for that operand.
    logic [LAT:0]  r_vld;
    logic [PW-1:0] r_dly [0:LAT];

    logic          r_busy;
    logic          r_done;
    logic [PW:0]   r_err_cnt;
    logic [31:0]   r_err_sum;
    logic [PW-1:0] r_err_max;
    logic [W-1:0]  r_worst_a;
    logic [W-1:0]  r_worst_b;

    logic          w_start_ok;
    logic          w_abort_ok;
    logic          w_issue;
    logic          w_acc;
    logic          w_last_acc;
    logic [W-1:0]  w_smp_a;
    logic [W-1:0]  w_smp_b;
    logic [PW-1:0] w_err;

    // Absolute difference between the returned and exact product, 2W bits unsigned.
    function automatic logic [PW-1:0] abs_err(
        input logic [PW-1:0] p,
        input logic [W-1:0]  a,
        input logic [W-1:0]  b
    );
        logic [PW-1:0] ex;
        ex = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        if (p >= ex) begin
            abs_err = p - ex;
        end else begin
            abs_err = ex - p;
        end
    endfunction

    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_abort_ok = abort && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
    assign w_issue    = (r_state == ST_RUN);
    assign w_acc      = r_vld[LAT];
    assign w_last_acc = w_acc && (r_dly[LAT] == LAST_IDX);
    assign w_smp_a    = r_dly[LAT][PW-1:W];
    assign w_smp_b    = r_dly[LAT][W-1:0];
    assign w_err      = abs_err(prod_ap, w_smp_a, w_smp_b);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Next-state logic; abort outranks completion while busy.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_nxt = ST_RUN;
                end else begin
                    w_nxt = r_state;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_nxt = ST_IDLE;
                end else if (r_dly[0] == PEN_IDX) begin
                    w_nxt = ST_DRAIN;
                end else begin
                    w_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    w_nxt = ST_IDLE;
                end else if (w_last_acc) begin
                    w_nxt = ST_DONE;
                end else begin
                    w_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_nxt = ST_IDLE;
            end
        endcase
    end

    // Status flags registered from the next state so they change with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_nxt == ST_RUN) || (w_nxt == ST_DRAIN);
            r_done <= (w_nxt == ST_DONE);
        end
    end

    // Operand index, delay line and error accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= '0;
            for (int j = 0; j <= LAT; j++) begin
                r_dly[j] <= '0;
            end
            r_err_cnt <= '0;
            r_err_sum <= 32'd0;
            r_err_max <= '0;
            r_worst_a <= '0;
            r_worst_b <= '0;
        end else if (w_start_ok) begin
            // Index 0 goes out on the start edge itself.
            r_vld     <= '0;
            r_vld[0]  <= 1'b1;
            r_dly[0]  <= '0;
            r_err_cnt <= '0;
            r_err_sum <= 32'd0;
            r_err_max <= '0;
            r_worst_a <= '0;
            r_worst_b <= '0;
        end else if (w_abort_ok) begin
            // Discard in-flight samples; results keep their partial values.
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_issue;
            for (int j = 1; j <= LAT; j++) begin
                r_vld[j] <= r_vld[j-1];
                r_dly[j] <= r_dly[j-1];
            end
            if (w_issue) begin
                r_dly[0] <= r_dly[0] + IDX_ONE;
            end else begin
                r_dly[0] <= r_dly[0];
            end
            if (w_acc) begin
                if (w_err != '0) begin
                    r_err_cnt <= r_err_cnt + CNT_ONE;
                    r_err_sum <= r_err_sum + 32'(w_err);
                end else begin
                    r_err_cnt <= r_err_cnt;
                    r_err_sum <= r_err_sum;
                end
                // Strictly greater: ties keep the earliest pair.
                if (w_err > r_err_max) begin
                    r_err_max <= w_err;
                    r_worst_a <= w_smp_a;
                    r_worst_b <= w_smp_b;
                end else begin
                    r_err_max <= r_err_max;
                    r_worst_a <= r_worst_a;
                    r_worst_b <= r_worst_b;
                end
            end else begin
                r_err_cnt <= r_err_cnt;
            end
        end
    end

    assign op_a    = r_dly[0][PW-1:W];
    assign op_b    = r_dly[0][W-1:0];
    assign busy    = r_busy;
    assign done    = r_done;
    assign err_cnt = r_err_cnt;
    assign err_sum = r_err_sum;
    assign err_max = r_err_max;
    assign worst_a = r_worst_a;
    assign worst_b = r_worst_b;

endmodule
